// File: rtl/csa_seq_ctrl_if.sv
// csa_seq_ctrl_if: operand/result handshake bundle for the sequential carry-select adder
interface csa_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/csa_seq_ctrl.sv
// csa_seq_ctrl: sequential adder, one SLICE-bit carry-select slice per cycle, LSB slice first
module csa_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input logic           clk,
    input logic           rst,
    csa_seq_ctrl_if.slave io
);
    localparam int NS = WIDTH / SLICE;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry, r_cout, r_ovf;
    logic [KW-1:0]    r_idx;
    logic [SLICE-1:0] w_ak, w_bk, w_s0, w_s1, w_sel;
    logic             w_c0, w_c1, w_csel, w_last;
    assign w_ak = r_a[int'(r_idx) * SLICE +: SLICE];
    assign w_bk = r_b[int'(r_idx) * SLICE +: SLICE];
    assign {w_c0, w_s0} = {1'b0, w_ak} + {1'b0, w_bk};
    assign {w_c1, w_s1} = {1'b0, w_ak} + {1'b0, w_bk} + (SLICE + 1)'(1);
    assign {w_csel, w_sel} = r_carry ? {w_c1, w_s1} : {w_c0, w_s0};
    assign w_last = r_idx == KW'(NS - 1);
    assign io.in_ready  = r_state == IDLE;
    assign io.out_valid = r_state == DONE;
    assign io.busy      = r_state != IDLE;
    assign io.sum       = r_sum;
    assign io.cout      = r_cout;
    assign io.ovf       = r_ovf;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (io.in_valid ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) :
                                     (io.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // the final slice also fixes cout and the sign-overflow flag from the captured operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == IDLE && io.in_valid) begin
            r_a     <= io.a;
            r_b     <= io.b;
            r_carry <= io.cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[int'(r_idx) * SLICE +: SLICE] <= w_sel;
            r_carry <= w_csel;
            r_idx   <= w_last ? r_idx : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_csel;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sel[SLICE-1] != r_a[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_csa_seq_ctrl.sv
// tb_csa_seq_ctrl: directed and randomized checks of csa_seq_ctrl against an a+b+cin model
module tb_csa_seq_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    csa_seq_ctrl_if #(.WIDTH(32)) bus ();
    csa_seq_ctrl_if #(.WIDTH(8))  bus8 ();
    csa_seq_ctrl u_dut (.clk(clk), .rst(rst), .io(bus.slave));
    csa_seq_ctrl #(.WIDTH(8), .SLICE(4)) u_dut8 (.clk(clk), .rst(rst), .io(bus8.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", n < 50, 1);
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic expect_op(input string tag, input logic [31:0] s, input logic co, input logic ov);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_sum"}, bus.sum, s);
        chk({tag, "_cout"}, bus.cout, co);
        chk({tag, "_ovf"}, bus.ovf, ov);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_rel_valid"}, bus.out_valid, 0);
        chk({tag, "_rel_ready"}, bus.in_ready, 1);
        chk({tag, "_rel_sum"}, bus.sum, s);
    endtask
    task automatic rand32(input int n);
        logic [31:0] a, b;
        logic        c;
        logic [32:0] r;
        int          t;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = ($urandom_range(7) == 0) ? ~a : $urandom;
            c = 1'($urandom);
            r = {1'b0, a} + {1'b0, b} + 33'(c);
            chk("r32_ready", bus.in_ready, 1);
            bus.a = a;
            bus.b = b;
            bus.cin = c;
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.cin = 1'($urandom);
            t = 0;
            while (t < 40) begin
                bus.out_ready = 1'($urandom_range(3) != 0);
                if (bus.out_valid && bus.out_ready) break;
                @(negedge clk);
                t++;
            end
            chk("r32_timeout", t < 40, 1);
            chk("r32_sum", bus.sum, r[31:0]);
            chk("r32_cout", bus.cout, r[32]);
            chk("r32_ovf", bus.ovf, (a[31] == b[31]) && (r[31] != a[31]));
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask
    task automatic rand8(input int n);
        logic [7:0] a, b;
        logic       c;
        logic [8:0] r;
        int         t;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            r = {1'b0, a} + {1'b0, b} + 9'(c);
            chk("r8_ready", bus8.in_ready, 1);
            bus8.a = a;
            bus8.b = b;
            bus8.cin = c;
            bus8.in_valid = 1'b1;
            @(negedge clk);
            bus8.in_valid = 1'($urandom);
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            t = 0;
            while (t < 40) begin
                bus8.out_ready = 1'($urandom_range(3) != 0);
                if (bus8.out_valid && bus8.out_ready) break;
                @(negedge clk);
                t++;
            end
            chk("r8_timeout", t < 40, 1);
            chk("r8_sum", bus8.sum, r[7:0]);
            chk("r8_cout", bus8.cout, r[8]);
            chk("r8_ovf", bus8.ovf, (a[7] == b[7]) && (r[7] != a[7]));
            bus8.in_valid = 1'b0;
            @(negedge clk);
            bus8.out_ready = 1'b0;
        end
    endtask
    initial begin
        int   lat;
        logic seen;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        {bus.in_valid, bus.a, bus.b, bus.cin, bus.out_ready} = '0;
        {bus8.in_valid, bus8.a, bus8.b, bus8.cin, bus8.out_ready} = '0;
        repeat (2) @(negedge clk);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.in_ready, 1);
        send(32'h0000_0001, 32'h0000_0002, 1'b0, lat);
        chk("add3_lat", lat, 8);
        expect_op("add3", 32'h0000_0003, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat);
        chk("ripple_lat", lat, 8);
        expect_op("ripple", 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        expect_op("ovf_pos", 32'h8000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        expect_op("ovf_neg", 32'h0000_0000, 1'b1, 1'b1);
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
            chk("stall_sum", bus.sum, 32'h1010_1011);
            chk("stall_ready", bus.in_ready, 0);
            chk("stall_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        expect_op("stall", 32'h1010_1011, 1'b0, 1'b0);
        chk("stall_busy", bus.busy, 0);
        @(negedge clk);
        bus.a = 32'h1234_5678;
        bus.b = 32'h1111_1111;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("abort_sum", bus.sum, 0);
        chk("abort_cout", bus.cout, 0);
        chk("abort_ovf", bus.ovf, 0);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= bus.out_valid | bus.busy;
        end
        chk("abort_quiet", seen, 0);
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, lat);
        chk("after_abort_lat", lat, 8);
        expect_op("after_abort", 32'hDEAD_BEF0, 1'b0, 1'b0);
        @(negedge clk);
        fork
            rand32(3000);
            rand8(10000);
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_seq_ctrl.md
CSA_SEQ_CTRL -- requirements
Module: csa_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, meaning bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, and NS = WIDTH/SLICE (default 8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a, b and cin are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the addends.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.
REQ-013 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-015 The block SHALL compute {cout,sum} = a + b + cin by sequencing one SLICE-bit carry-select slice over NS cycles, LSB slice first.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready = 1; on in_valid && in_ready the block SHALL capture a, b and cin into internal registers, clear the slice index to 0, load the carry register with cin, and go to RUN.
REQ-018 In RUN, each cycle, for slice k the block SHALL form s0/c0 = a_k + b_k + 0 and s1/c1 = a_k + b_k + 1, then select {s1,c1} if the carry register is 1, else {s0,c0}.
REQ-019 The selected sum bits SHALL be written to sum[k*SLICE +: SLICE], and the selected carry SHALL be written to the carry register at the same edge.
REQ-020 The slice index SHALL increment each RUN cycle; after slice NS-1 is written the FSM SHALL go to DONE, with no wrap to 0 inside RUN.
REQ-021 Latency SHALL be NS cycles: for a handshake at edge E0, out_valid is first high after edge E(NS), i.e. E8 by default.
REQ-022 In DONE, out_valid = 1, cout = the final carry, and ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using captured operands.
REQ-023 sum, cout and ovf SHALL stay stable while out_valid && !out_ready.
REQ-024 On out_valid && out_ready the FSM SHALL return to IDLE at that edge; sum, cout and ovf retain their values, and out_valid = 0.
REQ-025 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT alter captured operands.
REQ-026 out_ready while not in DONE SHALL have no effect.
REQ-027 Input port changes after capture SHALL NOT affect the result.
REQ-028 in_ready and out_valid SHALL be pure functions of state, with no combinational path from in_valid or out_ready.

Reset
REQ-029 While rst = 1 at a clock edge, state SHALL become IDLE and sum, cout, ovf, out_valid, busy, the carry register and the slice index SHALL become 0.
REQ-030 After reset release in_ready SHALL be 1.
REQ-031 rst asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; the next accepted operation SHALL be unaffected by the aborted one.
REQ-032 rst SHALL take priority over every simultaneous handshake.

Verification
REQ-033 The bench SHALL apply a=0x0000_0001, b=0x0000_0002, cin=0 and require sum=0x0000_0003, cout=0, ovf=0, with out_valid rising exactly 8 cycles after the handshake.
REQ-034 The bench SHALL apply a=0xFFFF_FFFF, b=0x0000_0000, cin=1 and require sum=0x0000_0000, cout=1, ovf=0, confirming the carry ripples through all 8 slices.
REQ-035 The bench SHALL apply a=0x7FFF_FFFF, b=0x0000_0001, cin=0 and require sum=0x8000_0000, cout=0, ovf=1; it SHALL then apply a=0x8000_0000, b=0x8000_0000 and require sum=0, cout=1, ovf=1.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b, and require sum stable, in_ready=0 and no new capture; then out_ready=1 for 1 cycle, requiring IDLE next and in_ready=1.
REQ-037 The bench SHALL assert rst at RUN slice 3 with a=0x1234_5678, b=0x1111_1111, and require all outputs 0 with no out_valid; it SHALL then send a=0xDEAD_BEEF, b=0x0000_0001, cin=0 and require sum=0xDEAD_BEF0.
REQ-038 The bench SHALL run a random regression of at least 10k back-to-back operations with random out_ready stalls, comparing against a golden a+b+cin model for sum, cout and ovf.
